sram_port_arbiter: RTL
======================

# sram_port_arbiter

Two-requester arbiter and sequencer for one single-port grid SRAM: the M, L or P memory of the shortest-path engine. Requester 0 is the path engine. Requester 1 is the host loader/readback port. The block grants one access per cycle and drives the registered SRAM En/Rw/Addr/Out signals. It tracks outstanding reads through a tag pipeline and returns read data to the requester that issued the read. An optional lock keeps the port owned across a multi-access step, such as the engine's read-L/read-L/write-L sequence.

## Interface
- D_WIDTH, 8, data width
- A_WIDTH, 13, address width (8192 words)
- RD_LAT, 2, cycles from the SRAM cycle with En=1/Rw=0 to valid S_In
- Clk  in  1  single clock, rising edge
- Rst  in  1  reset, asynchronous and active-low
- Req0, Req1  in  1  access request; held until granted (may be withdrawn before grant)
- Rw0, Rw1  in  1  1=write, 0=read
- Addr0, Addr1  in  A_WIDTH  word address
- WData0, WData1  in  D_WIDTH  write data
- Lock0, Lock1  in  1  request exclusive ownership after this grant
- Gnt0, Gnt1  out  1  combinational; access accepted this cycle
- RData0, RData1  out  D_WIDTH  registered read data
- RValid0, RValid1  out  1  one-cycle pulse, RData valid
- S_En, S_Rw  out  1  SRAM enable and write strobe
- S_Addr  out  A_WIDTH  SRAM address
- S_Out  out  D_WIDTH  SRAM write data
- S_In  in  D_WIDTH  SRAM read data

## Operation
- FSM states:
  - IDLE: either requester may be granted.
  - OWN0 / OWN1: only the owner may be granted; the other requester's Req is ignored and it waits.
- IDLE, Req0 only: grant 0. Req1 only: grant 1.
- IDLE, both requesting: winner is decided by the arbitration policy (see Configuration).
- A grant with Lock_i=1 moves the FSM to OWN_i.
- OWN_i returns to IDLE on the first cycle Lock_i is sampled 0, whether or not requester i is granted in that cycle.
- Reads: a grant with Rw=0 pushes {valid, owner} into an RD_LAT+1-deep tag shift register. When the tag emerges, S_In is captured into RData_owner and RValid_owner pulses.
- Tags are independent, so reads and writes may be interleaved back-to-back. Read data returns in issue order.
- Writes: S_Out=WData and S_Rw=1. Nothing is returned to the requester.
- No address range check; the A_WIDTH bits are passed through unchanged.
- Reset values: S_En=0, S_Rw=0, S_Addr=0, S_Out=0, RData0/1=0, RValid0/1=0, FSM=IDLE, tag pipeline cleared, round-robin pointer=1 (requester 0 wins the first tie).
- Gnt0/1 are 0 while Rst is low.
- Reset mid-operation: outstanding reads are discarded, and no RValid pulse is produced for them.

## Timing
- Arbitration cycle t: Gnt_i is high in t. The requester may change Req/Addr/Rw at the following edge.
- SRAM signals are registered: S_En, S_Rw, S_Addr and S_Out are valid in cycle t+1. S_En is low in any cycle with no grant in the previous cycle.
- Read return: S_In is valid in t+1+RD_LAT. RValid_i pulses in t+2+RD_LAT, i.e. t+4 at the default RD_LAT.
- Throughput: one grant per cycle, with no bubble between requesters.
- Gnt0 and Gnt1 are never high in the same cycle.
- A Req deasserted before grant produces no access.

## Configuration
- SRAM_ARB_RR_EN defined: IDLE ties are resolved round-robin. The requester not granted most recently wins. The pointer updates on every grant, including grants made in OWN states.
- SRAM_ARB_RR_EN undefined: fixed priority, requester 0 (the engine) always wins ties. The pointer is not built.

## Structure
- A shared package `sp_pkg` holds:
  - constants D_WIDTH, A_WIDTH, MAX=8192, SIZE_ROW=4;
  - the direction codes Start=8'h08, Right=8'h09, Down=8'h0A;
  - the arbiter state enum (IDLE, OWN0, OWN1);
  - the read-tag struct {valid, owner}.
- One sub-module, `sram_arb_tagpipe`: the RD_LAT+1-stage tag shift register with RValid decode, parameterised on RD_LAT.

## Test plan
- Read only: Req1 read Addr=13'h0005 with SRAM holding 8'h2A. Expect Gnt1 in cycle t, S_En=1/S_Rw=0/S_Addr=5 in t+1, RData1=8'h2A with RValid1 in t+4.
- Tie: Req0 and Req1 both high for 4 cycles. With RR_EN, grants go 0,1,0,1. Without RR_EN, grants go 0,0,0,0.
- Lock: Req0 with Lock0=1 for 3 accesses while Req1 is held high. Expect no Gnt1 until Lock0 drops, then Gnt1 in the next IDLE cycle.
- Pipelined mix: back-to-back read(0,A=3), write(1,A=4,D=8'h11), read(1,A=4). Expect RValid0 with M[3], then RValid1 returning 8'h11, in order with no stall cycles.
- Reset mid-read: assert Rst low one cycle after Gnt0 of a read. Expect every output at its reset value immediately, and no RValid0 after release.

Source files
------------

// File: rtl/sp_pkg.sv
// Shared types and constants for the shortest-path engine memories.
// Used by the SRAM port arbiter and its read-tag pipeline.
package sp_pkg;

    localparam int D_WIDTH  = 8;
    localparam int A_WIDTH  = 13;
    localparam int MAX      = 8192;
    localparam int SIZE_ROW = 4;

    localparam logic [7:0] Start = 8'h08;
    localparam logic [7:0] Right = 8'h09;
    localparam logic [7:0] Down  = 8'h0A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

endpackage

// File: rtl/sram_arb_tagpipe.sv
// Read-tag shift register: one stage per SRAM read-latency cycle plus the
// address register stage; the last stage lines up with valid S_In.
module sram_arb_tagpipe
    import sp_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  rd_tag_t push_i,
    output logic    rvalid0_o,
    output logic    rvalid1_o
);

    rd_tag_t [RD_LAT:0] tag_q;
    rd_tag_t [RD_LAT:0] tag_d;

    always_comb begin
        tag_d    = tag_q;
        tag_d[0] = push_i;
        for (int i = 1; i <= RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign rvalid0_o = tag_q[RD_LAT].valid & ~tag_q[RD_LAT].owner;
    assign rvalid1_o = tag_q[RD_LAT].valid &  tag_q[RD_LAT].owner;

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter/sequencer for one single-port grid SRAM.
// Define SRAM_ARB_RR_EN for round-robin ties; default is fixed priority (0 wins).
module sram_port_arbiter #(
    parameter int D_WIDTH = sp_pkg::D_WIDTH,
    parameter int A_WIDTH = sp_pkg::A_WIDTH,
    parameter int RD_LAT  = 2
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Req0,
    input  logic               Req1,
    input  logic               Rw0,
    input  logic               Rw1,
    input  logic [A_WIDTH-1:0] Addr0,
    input  logic [A_WIDTH-1:0] Addr1,
    input  logic [D_WIDTH-1:0] WData0,
    input  logic [D_WIDTH-1:0] WData1,
    input  logic               Lock0,
    input  logic               Lock1,
    output logic               Gnt0,
    output logic               Gnt1,
    output logic [D_WIDTH-1:0] RData0,
    output logic [D_WIDTH-1:0] RData1,
    output logic               RValid0,
    output logic               RValid1,
    output logic               S_En,
    output logic               S_Rw,
    output logic [A_WIDTH-1:0] S_Addr,
    output logic [D_WIDTH-1:0] S_Out,
    input  logic [D_WIDTH-1:0] S_In
);

    import sp_pkg::*;

    arb_state_t state_q;
    arb_state_t state_d;

    logic               gnt0;
    logic               gnt1;
    logic               gnt_any;
    logic               win1;
    logic               g_rw;
    logic [A_WIDTH-1:0] g_addr;
    logic [D_WIDTH-1:0] g_wdata;
    rd_tag_t            push;
    logic               rv0;
    logic               rv1;

    logic               s_en_q;
    logic               s_rw_q;
    logic [A_WIDTH-1:0] s_addr_q;
    logic [D_WIDTH-1:0] s_out_q;
    logic [D_WIDTH-1:0] rdata0_q;
    logic [D_WIDTH-1:0] rdata1_q;
    logic               rvalid0_q;
    logic               rvalid1_q;

`ifdef SRAM_ARB_RR_EN
    // Index of the requester granted most recently; the other one wins ties.
    logic last_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            last_q <= 1'b1;
        end else if (gnt_any) begin
            last_q <= gnt1;
        end
    end

    assign win1 = ~last_q;
`else
    assign win1 = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt0 && Lock0) begin
                    state_d = OWN0;
                end else if (gnt1 && Lock1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!Lock0) state_d = IDLE;
            end
            OWN1: begin
                if (!Lock1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (Rst) begin
            case (state_q)
                OWN0: gnt0 = Req0;
                OWN1: gnt1 = Req1;
                default: begin
                    gnt0 = Req0 & ~(Req1 & win1);
                    gnt1 = Req1 & ~(Req0 & ~win1);
                end
            endcase
        end
    end

    assign gnt_any = gnt0 | gnt1;
    assign g_rw    = gnt1 ? Rw1    : Rw0;
    assign g_addr  = gnt1 ? Addr1  : Addr0;
    assign g_wdata = gnt1 ? WData1 : WData0;

    assign push.valid = gnt_any & ~g_rw;
    assign push.owner = gnt1;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            s_en_q   <= 1'b0;
            s_rw_q   <= 1'b0;
            s_addr_q <= '0;
            s_out_q  <= '0;
        end else begin
            s_en_q <= gnt_any;
            s_rw_q <= gnt_any & g_rw;
            if (gnt_any) begin
                s_addr_q <= g_addr;
                s_out_q  <= g_wdata;
            end
        end
    end

    sram_arb_tagpipe #(
        .RD_LAT(RD_LAT)
    ) u_tagpipe (
        .clk_i    (Clk),
        .rst_ni   (Rst),
        .push_i   (push),
        .rvalid0_o(rv0),
        .rvalid1_o(rv1)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= rv0;
            rvalid1_q <= rv1;
            if (rv0) rdata0_q <= S_In;
            if (rv1) rdata1_q <= S_In;
        end
    end

    assign Gnt0    = gnt0;
    assign Gnt1    = gnt1;
    assign S_En    = s_en_q;
    assign S_Rw    = s_rw_q;
    assign S_Addr  = s_addr_q;
    assign S_Out   = s_out_q;
    assign RData0  = rdata0_q;
    assign RData1  = rdata1_q;
    assign RValid0 = rvalid0_q;
    assign RValid1 = rvalid1_q;

endmodule
